mips_multicycle_core: RTL and testbench
=======================================

Name: mips_multicycle_core

Overview:
- Parametrised multi-cycle MIPS-subset execution core; successor to the single-cycle instruction decoder/register-file block.
- Accepts 32-bit MIPS encodings over a valid/ready handshake and runs a 4-state FSM (IDLE, DECODE, EXEC, WB).
- Real register file of configurable depth, proper R/I/J decode, ALU, branch/jump PC update, registered result output.
- Instruction fetch and memory live outside this block.

Parameters:
- DATA_W, 32: register and ALU width; legal range 32..64. Immediates sign- or zero-extend to DATA_W.
- NUM_REGS, 32: register count; power of 2, 8..32. Register indices use the low log2(NUM_REGS) bits of each 5-bit field.
- PC_W, 32: PC width in bits; byte address, arithmetic modulo 2^PC_W.
- RESET_PC, 0: PC value after reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- instr  in  32  MIPS instruction word.
- instr_valid  in  1  instr is valid this cycle.
- instr_ready  out  1  core can accept an instruction; high only in IDLE.
- pc  out  PC_W  address of the next instruction to fetch.
- data_out  out  DATA_W  result of the last retired instruction.
- data_valid  out  1  one-cycle pulse; data_out updated this cycle.
- illegal  out  1  one-cycle pulse; last retired instruction was unsupported.
- dbg_addr  in  5  register-file debug read index (low bits used).
- dbg_data  out  DATA_W  combinational read of reg[dbg_addr]; r0 reads 0.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - pc=RESET_PC; data_out=0; data_valid=0; illegal=0.
  - All registers cleared to 0.
  - instr_ready=1 from the first cycle after rst deasserts.
  - Reset asserted mid-instruction aborts it: no register write, no PC change.
- Handshake:
  - Transfer occurs when instr_valid & instr_ready at a rising edge (cycle T).
  - instr is latched into IR at that edge. instr is ignored in every other state.
- FSM:
  - IDLE -> DECODE on transfer, else stay in IDLE.
  - DECODE: read rs/rt into A/B; build sign-extended and zero-extended immediates.
  - EXEC: ALU computes result; branch compare is evaluated.
  - WB: register write; pc, data_out, data_valid and illegal are registered at the end of WB (edge T+4); state returns to IDLE.
  - Throughput: 1 instruction per 4 cycles; instr_ready high again in cycle T+4.
- Supported instructions:
  - R-type (opcode 0) by funct: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A (signed). Destination is rd.
  - ADDI 0x08: sign-extended immediate; destination rt.
  - ORI 0x0D: zero-extended immediate; destination rt.
  - LUI 0x0F: imm<<16, sign-extended to DATA_W; destination rt.
  - BEQ 0x04: no register write. data_out = 1 if taken, else 0.
  - J 0x02: no register write. data_out = new pc, zero-extended.
- Arithmetic: wrap modulo 2^DATA_W; no overflow trap.
- Register r0:
  - Writes to r0 are discarded; r0 always reads 0.
  - data_out still shows the computed result and data_valid still pulses.
- PC update at WB:
  - Default: pc+4.
  - BEQ taken: pc+4+(sext(imm)<<2).
  - J: {pc_plus4[PC_W-1:28], target26, 2'b00}; if PC_W<=28, (target26<<2) truncated to PC_W.
  - All PC results wrap modulo 2^PC_W.
- Illegal opcode or funct:
  - No register write; pc+4; data_out unchanged.
  - illegal and data_valid pulse together.
- dbg_data reflects a WB write from the cycle after that write's edge.

Test Plan:
- Reset, then ADDI r1,r0,5 (0x20010005) -> instr_ready drops for 3 cycles; data_valid at T+4 with data_out=5; pc=0x4; dbg r1=5.
- ADDI r2,r0,-3 (0x2002FFFD), then ADD r3,r1,r2 (0x00221820), then SLT r4,r2,r1 (0x0041202A) -> data_out=0xFFFFFFFD, 2, 1; pc=0x10.
- LUI r5,0x1234 (0x3C051234) -> data_out=0x12340000. ADDI r0,r0,7 (0x20000007) -> data_out=7, dbg r0=0.
- BEQ r1,r1,+2 (0x10210002) at pc=0x18 -> pc=0x24, data_out=1. J 0x40 (0x08000040) -> pc=0x100.
- Opcode 0x3F word -> illegal and data_valid pulse; pc+4; no register changes. instr_valid held high during DECODE/EXEC/WB -> not accepted.
- Drop rst in EXEC of ADDI r6,r0,9 -> r6=0, pc=RESET_PC, no data_valid. NUM_REGS=8: write to r9 lands in r1.

Source files
------------

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-subset execution core: IDLE -> DECODE -> EXEC -> WB, one
// instruction per four cycles, with register file, ALU and branch/jump PC logic.
//
// state  | meaning
// IDLE   | waiting for instr_valid; instr_ready high
// DECODE | operand read from register file, immediates built
// EXEC   | ALU result, write target and next PC computed
// WB     | register write, pc/data_out/data_valid/illegal committed
module mips_multicycle_core #(
    parameter int               DATA_W   = 32,
    parameter int               NUM_REGS = 32,
    parameter int               PC_W     = 32,
    parameter logic [PC_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              illegal,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int RIDX_W = $clog2(NUM_REGS);
    // Bits of pc+4 that a J keeps; empty when the PC is 28 bits or narrower.
    localparam logic [PC_W-1:0] J_HI_MASK = ~PC_W'(28'hFFF_FFFF);

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;

    state_t              state_q, state_d;
    logic [31:0]         ir_q, ir_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, sext_q, sext_d, zext_q, zext_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic                we_q, we_d, ill_q, ill_d;
    logic [RIDX_W-1:0]   widx_q, widx_d;
    logic [PC_W-1:0]     npc_q, npc_d, pc_q, pc_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                data_valid_q, data_valid_d, illegal_q, illegal_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];

    logic [5:0]          opcode, funct;
    logic [15:0]         imm;
    logic [RIDX_W-1:0]   rs_idx, rt_idx, rd_idx;
    logic [PC_W-1:0]     pc_plus4, br_off, j_pc;

    assign opcode = ir_q[31:26];
    assign funct  = ir_q[5:0];
    assign imm    = ir_q[15:0];
    assign rs_idx = ir_q[21 +: RIDX_W];
    assign rt_idx = ir_q[16 +: RIDX_W];
    assign rd_idx = ir_q[11 +: RIDX_W];

    assign pc_plus4 = pc_q + PC_W'(4);
    assign br_off   = PC_W'($signed(imm)) << 2;
    assign j_pc     = (pc_plus4 & J_HI_MASK) | PC_W'({ir_q[25:0], 2'b00});

    // FSM next state, datapath staging and writeback commit.
    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        a_d          = a_q;
        b_d          = b_q;
        sext_d       = sext_q;
        zext_d       = zext_q;
        res_d        = res_q;
        we_d         = we_q;
        ill_d        = ill_q;
        widx_d       = widx_q;
        npc_d        = npc_q;
        pc_d         = pc_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        illegal_d    = 1'b0;
        regs_d       = regs_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = regs_q[rs_idx];
                b_d     = regs_q[rt_idx];
                sext_d  = DATA_W'($signed(imm));
                zext_d  = DATA_W'(imm);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                res_d   = '0;
                we_d    = 1'b0;
                ill_d   = 1'b0;
                widx_d  = rt_idx;
                npc_d   = pc_plus4;
                state_d = S_WB;
                case (opcode)
                    6'h00: begin
                        widx_d = rd_idx;
                        we_d   = 1'b1;
                        case (funct)
                            6'h20: res_d = a_q + b_q;
                            6'h22: res_d = a_q - b_q;
                            6'h24: res_d = a_q & b_q;
                            6'h25: res_d = a_q | b_q;
                            6'h2A: res_d = DATA_W'($signed(a_q) < $signed(b_q));
                            default: begin
                                we_d  = 1'b0;
                                ill_d = 1'b1;
                            end
                        endcase
                    end
                    6'h08: begin res_d = a_q + sext_q; we_d = 1'b1; end
                    6'h0D: begin res_d = a_q | zext_q; we_d = 1'b1; end
                    6'h0F: begin res_d = sext_q << 16; we_d = 1'b1; end
                    6'h04: begin
                        if (a_q == b_q) begin
                            res_d = DATA_W'(1);
                            npc_d = pc_plus4 + br_off;
                        end
                    end
                    6'h02: begin
                        npc_d = j_pc;
                        res_d = DATA_W'(j_pc);
                    end
                    default: ill_d = 1'b1;
                endcase
            end
            S_WB: begin
                if (we_q && widx_q != '0) regs_d[widx_q] = res_q;
                if (!ill_q) data_out_d = res_q;
                pc_d         = npc_q;
                data_valid_d = 1'b1;
                illegal_d    = ill_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any in-flight instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            ir_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            sext_q       <= '0;
            zext_q       <= '0;
            res_q        <= '0;
            we_q         <= 1'b0;
            ill_q        <= 1'b0;
            widx_q       <= '0;
            npc_q        <= RESET_PC;
            pc_q         <= RESET_PC;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            illegal_q    <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            ir_q         <= ir_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sext_q       <= sext_d;
            zext_q       <= zext_d;
            res_q        <= res_d;
            we_q         <= we_d;
            ill_q        <= ill_d;
            widx_q       <= widx_d;
            npc_q        <= npc_d;
            pc_q         <= pc_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            illegal_q    <= illegal_d;
            regs_q       <= regs_d;
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign pc          = pc_q;
    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign illegal     = illegal_q;
    assign dbg_data    = regs_q[dbg_addr[RIDX_W-1:0]];

endmodule

// File: tb/tb_mips_multicycle_core.sv
module tb_mips_multicycle_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] pc, data_out, dbg_data;
    logic        data_valid, illegal;
    logic [4:0]  dbg_addr = '0;

    logic [31:0] instr8 = '0;
    logic        valid8 = 1'b0;
    logic        ready8, dv8, ill8;
    logic [31:0] pc8, dout8, dbgd8;
    logic [4:0]  dbga8 = '0;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    logic [31:0] m_dout;

    always #5 clk = ~clk;

    mips_multicycle_core u_dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .pc(pc), .data_out(data_out),
        .data_valid(data_valid), .illegal(illegal),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    mips_multicycle_core #(.NUM_REGS(8)) u_dut8 (
        .clk(clk), .rst(rst), .instr(instr8), .instr_valid(valid8),
        .instr_ready(ready8), .pc(pc8), .data_out(dout8),
        .data_valid(dv8), .illegal(ill8),
        .dbg_addr(dbga8), .dbg_data(dbgd8)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_pc   = '0;
        m_dout = '0;
    endtask

    // Architectural effect of one instruction on the model state.
    task automatic model_exec(input logic [31:0] ins, output bit ill, output int dst);
        logic [31:0] a, b, r, simm, pc4, npc;
        bit          wr;
        a    = m_regs[ins[25:21]];
        b    = m_regs[ins[20:16]];
        simm = {{16{ins[15]}}, ins[15:0]};
        pc4  = m_pc + 32'd4;
        npc  = pc4;
        r    = '0;
        wr   = 1'b1;
        ill  = 1'b0;
        dst  = ins[20:16];
        case (ins[31:26])
            6'h00: begin
                dst = ins[15:11];
                case (ins[5:0])
                    6'h20: r = a + b;
                    6'h22: r = a - b;
                    6'h24: r = a & b;
                    6'h25: r = a | b;
                    6'h2A: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
                    default: ill = 1'b1;
                endcase
            end
            6'h08: r = a + simm;
            6'h0D: r = a | {16'h0, ins[15:0]};
            6'h0F: r = {ins[15:0], 16'h0};
            6'h04: begin
                wr = 1'b0;
                if (a == b) begin r = 32'd1; npc = pc4 + simm * 4; end
            end
            6'h02: begin
                wr  = 1'b0;
                npc = {pc4[31:28], ins[25:0], 2'b00};
                r   = npc;
            end
            default: ill = 1'b1;
        endcase
        if (ill) wr = 1'b0;
        if (wr && dst != 0) m_regs[dst] = r;
        if (!ill) m_dout = r;
        m_pc = npc;
    endtask

    // Issue one instruction from a negedge; returns at the negedge of data_valid.
    task automatic run_instr(input logic [31:0] ins, input bit hold);
        bit ill;
        int dst, cyc, probe;
        bit seen;
        chk("ready_idle", instr_ready, 1);
        instr = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = hold;
        instr = $urandom;
        model_exec(ins, ill, dst);
        seen = 0;
        cyc  = 0;
        while (!seen && cyc < 6) begin
            @(negedge clk);
            cyc++;
            if (data_valid) seen = 1;
            else chk("busy_ready", instr_ready, 0);
        end
        instr_valid = 1'b0;
        chk("dv_latency", cyc, 4);
        chk("data_out", data_out, m_dout);
        chk("illegal", illegal, ill);
        chk("pc", pc, m_pc);
        dbg_addr = dst[4:0];
        #1;
        chk("dbg_dst", dbg_data, m_regs[dst]);
        probe = $urandom_range(0, 31);
        dbg_addr = probe[4:0];
        #1;
        chk("dbg_probe", dbg_data, m_regs[probe]);
    endtask

    task automatic run8(input logic [31:0] ins, input logic [31:0] exp_out);
        int cyc;
        instr8 = ins;
        valid8 = 1'b1;
        @(posedge clk);
        #1;
        valid8 = 1'b0;
        cyc = 0;
        while (!dv8 && cyc < 6) begin
            @(negedge clk);
            cyc++;
        end
        chk("n8_latency", cyc, 4);
        chk("n8_data_out", dout8, exp_out);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [5:0]  functs [5];
        logic [5:0]  bad_fn [4];
        logic [5:0]  bad_op [4];
        functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        bad_fn = '{6'h21, 6'h23, 6'h00, 6'h3F};
        bad_op = '{6'h3F, 6'h23, 6'h2B, 6'h05};
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        rd  = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
        imm = 16'($urandom);
        case ($urandom_range(0, 9))
            0, 1, 2: return {6'h00, rs, rt, rd, 5'd0, functs[$urandom_range(0, 4)]};
            3:       return {6'h08, rs, rt, imm};
            4:       return {6'h0D, rs, rt, imm};
            5:       return {6'h0F, 5'd0, rt, imm};
            6:       return {6'h04, rs, ($urandom_range(0, 1) == 1) ? rs : rt, imm};
            7:       return {6'h02, 26'($urandom)};
            8:       return {6'h00, rs, rt, rd, 5'd0, bad_fn[$urandom_range(0, 3)]};
            default: return {bad_op[$urandom_range(0, 3)], 26'($urandom)};
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, 32'h0);
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_illegal", illegal, 0);
        rst = 1'b1;
        @(negedge clk);

        run_instr(32'h20010005, 1'b0);
        run_instr(32'h2002FFFD, 1'b1);
        run_instr(32'h00221820, 1'b0);
        run_instr(32'h0041202A, 1'b1);
        chk("pc_after_slt", pc, 32'h10);
        run_instr(32'h3C051234, 1'b0);
        run_instr(32'h20000007, 1'b1);
        chk("bea_pc_start", pc, 32'h18);
        run_instr(32'h10210002, 1'b0);
        run_instr(32'h08000040, 1'b1);
        run_instr(32'hFC000000, 1'b1);
        run_instr(32'h00221822, 1'b0);

        for (int i = 0; i < 150; i++)
            run_instr(rand_instr(), 1'($urandom_range(0, 1)));

        // Abort an ADDI r6,r0,9 with reset while it is in EXEC.
        instr = 32'h20060009;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        chk("abort_pc", pc, 32'h0);
        chk("abort_data_out", data_out, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_no_dv", data_valid, 0);
            chk("abort_ready", instr_ready, 1);
        end
        dbg_addr = 5'd6;
        #1;
        chk("abort_r6", dbg_data, 32'h0);
        dbg_addr = 5'd1;
        #1;
        chk("abort_r1", dbg_data, 32'h0);
        @(negedge clk);
        run_instr(32'h20060009, 1'b0);

        // Eight-register instance: index 9 aliases to r1, index 8 to r0.
        @(negedge clk);
        run8(32'h20090055, 32'h55);
        dbga8 = 5'd1;
        #1;
        chk("n8_r1", dbgd8, 32'h55);
        dbga8 = 5'd9;
        #1;
        chk("n8_r9", dbgd8, 32'h55);
        @(negedge clk);
        run8(32'h20080077, 32'h77);
        dbga8 = 5'd0;
        #1;
        chk("n8_r0", dbgd8, 32'h0);
        chk("n8_pc", pc8, 32'h8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
